// File: rtl/instr_mem_loader.sv
// instr_mem_loader: bursts instruction words from DDR into a circular buffer read by top_fsm.
// Define INSTR_PREFETCH_EN to refill whenever space allows, ignoring fetch_req.
module instr_mem_loader #(
    parameter int AW     = 10,
    parameter int DW     = 64,
    parameter int BURST  = 16,
    parameter int DDR_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DDR_AW-1:0] base_addr,
    input  logic [15:0]       prog_len,
    input  logic              start,
    input  logic              fetch_req,
    output logic              ddr_rd_req,
    output logic [DDR_AW-1:0] ddr_rd_addr,
    output logic [7:0]        ddr_rd_len,
    input  logic              ddr_rd_ack,
    input  logic              ddr_rd_valid,
    input  logic [DW-1:0]     ddr_rd_data,
    input  logic              ddr_rd_last,
    input  logic [AW-1:0]     i_mem_addr,
    input  logic              i_mem_rd_enable,
    output logic [DW-1:0]     i_mem_din,
    output logic              i_mem_empty,
    output logic              load_done
);
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
    localparam logic [AW:0]       DEPTH  = (AW+1)'(2**AW);
    localparam logic [AW:0]       BSPACE = (AW+1)'(BURST);
    localparam logic [15:0]       B16    = 16'(BURST);
    localparam logic [DDR_AW-1:0] STRIDE = DDR_AW'(BURST*DW/8);
    state_t        state;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   occ, occ_next;
    logic [15:0]   loaded, len_q, rem;
    logic [8:0]    cnt;
    logic          fetch_en, acc, rd, go;
`ifdef INSTR_PREFETCH_EN
    logic unused_fetch;
    assign unused_fetch = fetch_req;
    assign fetch_en = 1'b1;
`else
    assign fetch_en = fetch_req;
`endif
    always_comb begin
        acc      = state == DATA && ddr_rd_valid && cnt <= {1'b0, ddr_rd_len};
        rd       = i_mem_rd_enable && occ != '0;
        occ_next = occ + (AW+1)'(acc) - (AW+1)'(rd);
        rem      = len_q - loaded;
        go       = fetch_en && !load_done && loaded != len_q && (DEPTH - occ) >= BSPACE;
    end
    always_ff @(posedge clk)
        if (acc) mem[wr_ptr] <= ddr_rd_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ddr_rd_req  <= 1'b0;
            ddr_rd_addr <= '0;
            ddr_rd_len  <= '0;
            i_mem_din   <= '0;
            i_mem_empty <= 1'b1;
            load_done   <= 1'b0;
            wr_ptr      <= '0;
            occ         <= '0;
            loaded      <= '0;
            len_q       <= '0;
            cnt         <= '0;
        end else begin
            i_mem_din <= mem[i_mem_addr];
            if (start) begin
                state       <= IDLE;
                ddr_rd_req  <= 1'b0;
                ddr_rd_addr <= base_addr;
                len_q       <= prog_len;
                wr_ptr      <= '0;
                occ         <= '0;
                loaded      <= '0;
                i_mem_empty <= 1'b1;
                load_done   <= prog_len == 16'd0;
            end else begin
                occ         <= occ_next;
                i_mem_empty <= occ_next == '0;
                if (acc) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    loaded    <= loaded + 16'd1;
                    cnt       <= cnt + 9'd1;
                    load_done <= loaded + 16'd1 == len_q;
                end
                case (state)
                    IDLE: if (go) begin
                        state      <= REQ;
                        ddr_rd_req <= 1'b1;
                        ddr_rd_len <= rem >= B16 ? 8'(BURST - 1) : 8'(rem - 16'd1);
                    end
                    REQ: if (ddr_rd_ack) begin
                        state      <= DATA;
                        ddr_rd_req <= 1'b0;
                        cnt        <= '0;
                    end
                    DATA: if (ddr_rd_valid && ddr_rd_last) begin
                        state       <= IDLE;
                        ddr_rd_addr <= ddr_rd_addr + STRIDE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized DDR/consumer stimulus with a queue-based scoreboard.
module tb_instr_mem_loader;
    localparam int AW = 10, DW = 64, BURST = 16, DEPTH = 1024;
    logic          clk = 0, rst = 0, start = 0, fetch_req = 1;
    logic [31:0]   base_addr = 0;
    logic [15:0]   prog_len = 0;
    logic          ddr_rd_req, ddr_rd_ack = 0, ddr_rd_valid = 0, ddr_rd_last = 0;
    logic [31:0]   ddr_rd_addr;
    logic [7:0]    ddr_rd_len;
    logic [63:0]   ddr_rd_data = 0;
    logic [AW-1:0] i_mem_addr = 0;
    logic          i_mem_rd_enable = 0;
    logic [DW-1:0] i_mem_din;
    logic          i_mem_empty, load_done;

    instr_mem_loader #(.AW(AW), .DW(DW), .BURST(BURST), .DDR_AW(32)) dut (
        .clk(clk), .rst(rst), .base_addr(base_addr), .prog_len(prog_len), .start(start),
        .fetch_req(fetch_req), .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr),
        .ddr_rd_len(ddr_rd_len), .ddr_rd_ack(ddr_rd_ack), .ddr_rd_valid(ddr_rd_valid),
        .ddr_rd_data(ddr_rd_data), .ddr_rd_last(ddr_rd_last), .i_mem_addr(i_mem_addr),
        .i_mem_rd_enable(i_mem_rd_enable), .i_mem_din(i_mem_din), .i_mem_empty(i_mem_empty),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int kind; logic [63:0] exp;} ent_t;
    typedef struct {logic [31:0] addr; logic [7:0] len;} req_t;
    ent_t exq[$];
    req_t req_q[$];
    int compared = 0, mismatched = 0, cyc = 0;
    int occ_m = 0, total_m = 0, len_m = 0, rd_prob = 50, holdcnt = 0;
    bit ld_m = 0, hold = 0;
    logic [31:0] base_m = 0;
    logic [63:0] refm [DEPTH];
    int dstate = 0, dwait = 0, beats_left = 0, bidx = 0;
    bit extra = 0, stale = 0, rst_now = 0, start_now = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] word_of(int idx);
        return {32'hC0DE_0000 ^ 32'(idx), base_m + 32'(idx) * 8};
    endfunction

    task automatic push(int k, logic [63:0] v);
        exq.push_back('{cyc + 1, k, v});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        req_t r;
        ent_t e;
        if (ddr_rd_req && ddr_rd_ack) begin
            if (req_q.size() == 0) check("req_extra", {32'b0, ddr_rd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                r = req_q.pop_front();
                check("req_addr", {32'b0, ddr_rd_addr}, {32'b0, r.addr});
                check("req_len", {56'b0, ddr_rd_len}, {56'b0, r.len});
            end
        end
        while (exq.size() > 0 && exq[0].due <= cyc) begin
            e = exq.pop_front();
            case (e.kind)
                0: check("din", i_mem_din, e.exp);
                1: check("empty", {63'b0, i_mem_empty}, e.exp);
                2: check("load_done", {63'b0, load_done}, e.exp);
                default: check("reset_bus", {23'b0, ddr_rd_req, ddr_rd_addr, ddr_rd_len}, e.exp);
            endcase
        end
    end

    task automatic step();
        bit acc, rdok;
        int n;
        @(posedge clk);
        #1;
        ddr_rd_ack = 0; ddr_rd_valid = 0; ddr_rd_last = 0; acc = 0;
        rst = rst_now; start = start_now;
        if (rst_now || start_now) begin
            if (dstate == 1) dstate = 0;
            if (dstate == 2) stale = 1;
        end
        if (dstate == 0 && ddr_rd_req && !rst_now && !start_now) begin
            dwait = $urandom_range(0, 2);
            dstate = 1;
        end
        if (dstate == 1) begin
            if (dwait == 0) begin
                ddr_rd_ack = 1;
                beats_left = int'(ddr_rd_len) + 1;
                bidx = int'((ddr_rd_addr - base_m) >> 3);
                extra = ($urandom_range(0, 3) == 0);
                dstate = 2;
            end else dwait--;
        end else if (dstate == 2 && $urandom_range(0, 3) != 0) begin
            ddr_rd_valid = 1;
            if (beats_left > 0) begin
                ddr_rd_data = word_of(bidx);
                ddr_rd_last = (beats_left == 1 && !extra);
                acc = !stale && !rst_now && !start_now;
                beats_left--;
                bidx++;
            end else begin
                ddr_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
                ddr_rd_last = 1;
            end
            if (ddr_rd_last) begin dstate = 0; stale = 0; end
        end
        i_mem_rd_enable = !hold && ($urandom_range(0, 99) < rd_prob);
        n = total_m < DEPTH ? total_m : DEPTH;
        i_mem_addr = 10'(n > 0 ? $urandom_range(0, n - 1) : $urandom_range(0, DEPTH - 1));
        if (rst_now) begin
            occ_m = 0; total_m = 0; len_m = 0; ld_m = 0;
            req_q.delete();
            push(0, 64'd0); push(1, 64'd1); push(2, 64'd0); push(3, 64'd0);
        end else if (start_now) begin
            base_m = base_addr; len_m = int'(prog_len);
            occ_m = 0; total_m = 0; ld_m = (len_m == 0);
            req_q.delete();
            for (int k = 0; k * BURST < len_m; k++)
                req_q.push_back('{base_m + 32'(k * BURST * 8),
                                  8'((len_m - k * BURST < BURST ? len_m - k * BURST : BURST) - 1)});
            push(1, 64'd1); push(2, {63'b0, ld_m});
        end else begin
            if (total_m > 0) push(0, refm[i_mem_addr]);
            rdok = i_mem_rd_enable && occ_m > 0;
            occ_m = occ_m + int'(acc) - int'(rdok);
            if (acc) begin
                refm[total_m % DEPTH] = ddr_rd_data;
                total_m++;
                ld_m = (total_m == len_m);
            end
            if (occ_m > DEPTH) check("overflow", 64'(occ_m), 64'(DEPTH));
            push(1, {63'b0, occ_m == 0}); push(2, {63'b0, ld_m});
        end
        rst_now = 0; start_now = 0;
    endtask

    task automatic load(logic [31:0] b, int len);
        base_addr = b; prog_len = 16'(len); start_now = 1;
        step();
    endtask

    task automatic run_done(int budget);
        int i;
        for (i = 0; i < budget && !(ld_m && req_q.size() == 0 && dstate == 0); i++) begin
            if (hold && occ_m == DEPTH) holdcnt++;
            if (holdcnt > 20) hold = 0;
            step();
        end
        if (i == budget) begin
            compared++; mismatched++;
            $display("FAIL timeout: loaded %0d of %0d, %0d requests outstanding", total_m, len_m, req_q.size());
        end
        repeat (3) step();
    endtask

    initial begin
        rst_now = 1; step(); step();
        load(32'h1000, 4); run_done(400);
        load(32'h1000, 40); run_done(800);
        load(32'h2000, 0); run_done(50);
        for (int t = 0; t < 3; t++) begin
            rd_prob = $urandom_range(20, 95);
            load({$urandom_range(0, 32'h00FF_FFFF), 3'b0}, $urandom_range(1, 200));
            run_done(3000);
        end
        rd_prob = 50; hold = 1; holdcnt = 0;
        load(32'h0010_0000, 1100); run_done(6000);
        hold = 0;
        load(32'h4000, 64);
        for (int i = 0; i < 400 && total_m < 5; i++) step();
        rst_now = 1; step();
        repeat (30) step();
        load(32'h5000, 48);
        for (int i = 0; i < 400 && total_m < 3; i++) step();
        load(32'h6000, 20); run_done(800);
        fetch_req = 0;
        load(32'h7000, 32);
        repeat (30) step();
`ifdef INSTR_PREFETCH_EN
        check("prefetch_issued", {63'b0, req_q.size() < 2}, 64'd1);
`else
        check("no_fetch_no_req", 64'(req_q.size()), 64'd2);
`endif
        fetch_req = 1;
        run_done(800);
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
